// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx
// Mono audio back-end. Mixes the 8-bit unsigned PSG stream with a 16-bit
// signed auxiliary source, attenuates and saturates the result to 16 bits,
// and serialises it as standard I2S with the same sample in both slots.
//
// Ports:
//   clk_27m        system clock (single domain)
//   reset          synchronous, active-high reset
//   psg_in   [7:0] unsigned PSG sample, 0x80 = silence
//   aux_in  [15:0] signed auxiliary sample
//   atten    [2:0] arithmetic right shift applied to the mix
//   mute           forces the mixed sample to zero
//   i2s_bclk       bit clock
//   i2s_lrclk      word select (0 = left, 1 = right)
//   i2s_sdata      serial data, MSB first, one BCLK after each LRCLK edge
//   sample_strobe  one-cycle pulse when a new sample is latched for a frame
module audio_i2s_tx #(
  parameter int BCLK_HALF = 4,
  parameter int PSG_SHIFT = 7
) (
  input  logic               clk_27m,
  input  logic               reset,
  input  logic [7:0]         psg_in,
  input  logic signed [15:0] aux_in,
  input  logic [2:0]         atten,
  input  logic               mute,
  output logic               i2s_bclk,
  output logic               i2s_lrclk,
  output logic               i2s_sdata,
  output logic               sample_strobe
);

  localparam int DIV_W = (BCLK_HALF > 2) ? $clog2(BCLK_HALF) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);

  function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
    if (v > 17'sd32767)
      return 16'sh7fff;
    else if (v < -17'sd32768)
      return 16'sh8000;
    else
      return v[15:0];
  endfunction

  logic [7:0]         psg_c;
  logic signed [15:0] psg_s;
  logic signed [16:0] sum;
  logic signed [16:0] sh;
  logic signed [15:0] mix_p0;

  logic [DIV_W-1:0]   div_cnt;
  logic [5:0]         bit_cnt;
  logic [5:0]         bit_nxt;
  logic [4:0]         slot_p;
  logic [3:0]         bit_idx;
  logic               data_bit;
  logic               tick;
  logic               fall;
  logic signed [15:0] frame_smp;

  // Mix stage: re-centre PSG, add aux at 17 bits, shift, saturate.
  always_comb begin
    psg_c = psg_in ^ 8'h80;
    psg_s = $signed({{8{psg_c[7]}}, psg_c}) <<< PSG_SHIFT;
    sum   = $signed({psg_s[15], psg_s}) + $signed({aux_in[15], aux_in});
    sh    = sum >>> atten;
  end

  always_ff @(posedge clk_27m) begin
    if (reset)
      mix_p0 <= '0;
    else if (mute)
      mix_p0 <= '0;
    else
      mix_p0 <= sat16(sh);
  end

  // Serialiser: outputs change on the BCLK falling tick so the DAC sees
  // stable data on the rising edge. Slot bit p=1..16 carries sample bit 16-p;
  // p=0 is the one-BCLK I2S delay after LRCLK, p>16 is zero padding.
  always_comb begin
    tick     = (div_cnt == DIV_LAST);
    fall     = tick & i2s_bclk;
    bit_nxt  = bit_cnt + 6'd1;
    slot_p   = bit_nxt[4:0];
    bit_idx  = 4'(5'd16 - slot_p);
    data_bit = 1'b0;
    if (slot_p >= 5'd1 && slot_p <= 5'd16)
      data_bit = frame_smp[bit_idx];
  end

  always_ff @(posedge clk_27m) begin
    if (reset) begin
      div_cnt       <= '0;
      i2s_bclk      <= 1'b0;
      bit_cnt       <= 6'd63;
      i2s_lrclk     <= 1'b1;
      i2s_sdata     <= 1'b0;
      sample_strobe <= 1'b0;
      frame_smp     <= '0;
    end else begin
      sample_strobe <= 1'b0;
      div_cnt       <= tick ? '0 : div_cnt + 1'b1;
      if (tick)
        i2s_bclk <= ~i2s_bclk;
      if (fall) begin
        bit_cnt   <= bit_nxt;
        i2s_lrclk <= bit_nxt[5];
        i2s_sdata <= data_bit;
        // Frame start: latch the mix registered on the previous cycle.
        if (bit_nxt == 6'd0) begin
          frame_smp     <= mix_p0;
          sample_strobe <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Testbench for audio_i2s_tx: directed scenarios plus randomized frames,
// decoding the I2S pins back into samples and comparing against an
// arithmetic reference of the mix.
module tb_audio_i2s_tx;

  localparam int BH = 4;
  localparam int PS = 7;

  logic        clk_27m = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  psg_in = 8'h80;
  logic [15:0] aux_in = 16'h0000;
  logic [2:0]  atten = 3'd0;
  logic        mute = 1'b0;
  logic        i2s_bclk, i2s_lrclk, i2s_sdata, sample_strobe;

  int checks = 0;
  int errors = 0;

  audio_i2s_tx #(.BCLK_HALF(BH), .PSG_SHIFT(PS)) dut (
    .clk_27m(clk_27m), .reset(reset), .psg_in(psg_in), .aux_in(aux_in),
    .atten(atten), .mute(mute), .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk),
    .i2s_sdata(i2s_sdata), .sample_strobe(sample_strobe)
  );

  always #5 clk_27m = ~clk_27m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: integer arithmetic, floor division for the shift, clamp.
  function automatic logic [15:0] model(input logic [7:0] psg, input logic [15:0] aux,
                                        input logic [2:0] att, input logic m);
    int p, a, s, d, q;
    if (m) return 16'h0000;
    p = (int'(psg) - 128) * (1 << PS);
    a = int'($signed(aux));
    s = p + a;
    d = 1 << att;
    if (s >= 0) q = s / d;
    else        q = -((-s + d - 1) / d);
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
    return 16'(q);
  endfunction

  task automatic step;
    @(posedge clk_27m); #1;
  endtask

  task automatic wait_strobe(output bit ok);
    int budget;
    budget = 0;
    do begin step(); budget++; end while (!sample_strobe && budget < 300 * BH);
    ok = sample_strobe;
    check("strobe_wait", {31'd0, sample_strobe}, 32'd1);
  endtask

  // Decode one frame from the pins, sampling on BCLK rising edges.
  task automatic recv(input int chg_at, input logic [15:0] new_aux,
                      output logic [15:0] l, output logic [15:0] r, output int msb_idx);
    int budget, idx, p;
    logic pb;
    bit pad_ok, lr_ok, ok;
    l = '0; r = '0; msb_idx = -1; pad_ok = 1; lr_ok = 1;
    wait_strobe(ok);
    if (!ok) return;
    pb = i2s_bclk; idx = 0; budget = 0;
    while (idx < 64 && budget < 200 * BH) begin
      step(); budget++;
      if (i2s_bclk && !pb) begin
        p = idx % 32;
        if (i2s_lrclk !== (idx >= 32)) lr_ok = 0;
        if (p >= 1 && p <= 16) begin
          if (idx < 32) l[16-p] = i2s_sdata;
          else          r[16-p] = i2s_sdata;
        end else if (i2s_sdata !== 1'b0) pad_ok = 0;
        if (i2s_sdata === 1'b1 && msb_idx < 0) msb_idx = idx;
        if (idx == chg_at) aux_in = new_aux;
        idx++;
      end
      pb = i2s_bclk;
    end
    check("frame_bits", idx, 64);
    check("pad_zero", {31'd0, pad_ok}, 32'd1);
    check("lrclk_slot", {31'd0, lr_ok}, 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_bclk"}, {31'd0, i2s_bclk}, 32'd0);
    check({tag, "_lrclk"}, {31'd0, i2s_lrclk}, 32'd1);
    check({tag, "_sdata"}, {31'd0, i2s_sdata}, 32'd0);
    check({tag, "_strobe"}, {31'd0, sample_strobe}, 32'd0);
  endtask

  // Called right after reset is released; covers the first two frame starts.
  task automatic check_startup(input string tag);
    int first_s, last_s, n_s;
    first_s = -1; last_s = -1; n_s = 0;
    for (int n = 1; n <= 130 * BH; n++) begin
      step();
      if (n == BH - 1) check({tag, "_bclk_low"}, {31'd0, i2s_bclk}, 32'd0);
      if (n == BH)     check({tag, "_bclk_rise"}, {31'd0, i2s_bclk}, 32'd1);
      if (n == 2 * BH) begin
        check({tag, "_bclk_fall"}, {31'd0, i2s_bclk}, 32'd0);
        check({tag, "_lrclk_left"}, {31'd0, i2s_lrclk}, 32'd0);
      end
      if (sample_strobe) begin
        n_s++;
        last_s = n;
        if (first_s < 0) first_s = n;
      end
    end
    check({tag, "_first_strobe"}, first_s, 2 * BH);
    check({tag, "_second_strobe"}, last_s, 130 * BH);
    check({tag, "_strobe_count"}, n_s, 2);
  endtask

  logic [15:0] l, r, exp;
  int msb_idx, falls;
  logic pb;
  bit ok;

  initial begin
    // Reset / first frame
    repeat (5) step();
    check_reset_vals("reset");
    reset = 1'b0;
    check_startup("startup");

    // Silence
    psg_in = 8'h80; aux_in = 16'h0000; atten = 3'd0; mute = 1'b0;
    recv(-1, 16'h0, l, r, msb_idx);
    check("silence_l", {16'd0, l}, 32'h0000);
    check("silence_r", {16'd0, r}, 32'h0000);
    check("silence_nobits", msb_idx, -1);

    // Positive / negative saturation
    psg_in = 8'hFF; aux_in = 16'h7FFF;
    recv(-1, 16'h0, l, r, msb_idx);
    check("satpos_l", {16'd0, l}, 32'h7FFF);
    check("satpos_r", {16'd0, r}, 32'h7FFF);
    psg_in = 8'h00; aux_in = 16'h8000;
    recv(-1, 16'h0, l, r, msb_idx);
    check("satneg_l", {16'd0, l}, 32'h8000);
    check("satneg_r", {16'd0, r}, 32'h8000);
    check("msb_pos", msb_idx, 1);

    // Attenuation then mute
    psg_in = 8'hC0; aux_in = 16'h0000; atten = 3'd3;
    recv(-1, 16'h0, l, r, msb_idx);
    check("atten_l", {16'd0, l}, 32'h0400);
    check("atten_r", {16'd0, r}, 32'h0400);
    mute = 1'b1;
    recv(-1, 16'h0, l, r, msb_idx);
    check("mute_l", {16'd0, l}, 32'h0000);
    check("mute_r", {16'd0, r}, 32'h0000);

    // Frame isolation: aux changes at left slot position 8
    mute = 1'b0; atten = 3'd0; psg_in = 8'h80; aux_in = 16'h1234;
    recv(8, 16'h4321, l, r, msb_idx);
    check("iso_cur_l", {16'd0, l}, 32'h1234);
    check("iso_cur_r", {16'd0, r}, 32'h1234);
    recv(-1, 16'h0, l, r, msb_idx);
    check("iso_next_l", {16'd0, l}, 32'h4321);
    check("iso_next_r", {16'd0, r}, 32'h4321);

    // Randomized frames against the reference
    for (int k = 0; k < 10; k++) begin
      psg_in = 8'($urandom_range(0, 255));
      aux_in = 16'($urandom);
      atten  = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
      mute   = ($urandom_range(0, 7) == 0);
      exp = model(psg_in, aux_in, atten, mute);
      recv(-1, 16'h0, l, r, msb_idx);
      check("rand_l", {16'd0, l}, {16'd0, exp});
      check("rand_r", {16'd0, r}, {16'd0, exp});
    end

    // Reset mid-frame at bit_cnt = 40
    wait_strobe(ok);
    if (ok) begin
      falls = 0; pb = i2s_bclk;
      for (int n = 0; n < 100 * BH && falls < 40; n++) begin
        step();
        if (!i2s_bclk && pb) falls++;
        pb = i2s_bclk;
      end
      check("midrst_pos", falls, 40);
      check("midrst_lrclk_right", {31'd0, i2s_lrclk}, 32'd1);
      reset = 1'b1;
      step();
      check_reset_vals("midrst");
      reset = 1'b0;
      check_startup("restart");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_i2s_tx.md
# audio_i2s_tx

Mono audio back-end that consumes the 8-bit unsigned filtered PSG stream and a 16-bit signed auxiliary source. It mixes and attenuates them, saturates the result to 16-bit signed, and serialises each sample as standard I2S on both channels for the board's external DAC/amplifier. It sits directly downstream of the PSG low-pass filter chain (`psg_filter.data_out` → `psg_in`) and drives the audio pins.

## Interface
- `BCLK_HALF`, default 4: `clk_27m` cycles per BCLK half-period. Must be ≥ 2. Frame rate = 27 MHz / (128·BCLK_HALF), i.e. 52.73 kHz at the default.
- `PSG_SHIFT`, default 7: left shift applied to the re-centred PSG value.

Ports:
- `clk_27m`  in  1  system clock. Single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `psg_in`  in  8  unsigned PSG sample; 0x80 = silence.
- `aux_in`  in  16  signed two's-complement auxiliary sample.
- `atten`  in  3  arithmetic right shift applied to the mix (0 = full scale).
- `mute`  in  1  forces the mixed sample to 0.
- `i2s_bclk`  out  1  bit clock.
- `i2s_lrclk`  out  1  word select (0 = left, 1 = right).
- `i2s_sdata`  out  1  serial data, MSB first.
- `sample_strobe`  out  1  one-cycle pulse when a new sample is latched for a frame.

## Operation
- **Mix stage** (registered every `clk_27m`, 1-cycle latency):
  - `psg_s` = sign-extend(`psg_in` ^ 0x80) << PSG_SHIFT, as 16-bit signed.
  - `sum` = `psg_s` + `aux_in`, computed at 17 bits (no overflow possible).
  - `sh` = `sum` >>> `atten` (arithmetic shift).
  - Saturate to [-32768, 32767], giving `mix`.
  - When `mute` = 1, `mix` = 0.
- **Divider:** `div_cnt` counts 0..BCLK_HALF-1. At BCLK_HALF-1 it wraps to 0 and issues a tick, and `i2s_bclk` toggles on that tick.
- **Falling tick** (`i2s_bclk` 1→0):
  - `bit_cnt` (6 bits) increments modulo 64. All serial outputs update here, so the DAC samples them on the BCLK rising edge.
  - `i2s_lrclk` = new `bit_cnt[5]`.
  - Slot position `p` = `bit_cnt[4:0]`. `i2s_sdata` = `frame_smp[16-p]` for p = 1..16, and 0 for p = 0 and p = 17..31. The MSB therefore appears one BCLK after each LRCLK edge (standard I2S, 16 data bits in 32-bit slots).
  - When the new `bit_cnt` = 0, `frame_smp` ← `mix` and `sample_strobe` pulses high for exactly that one `clk_27m` cycle.
  - Left and right slots of a frame carry the same `frame_smp`.
- **Rising tick:** only `i2s_bclk` toggles.
- Input changes during a frame never alter the frame in flight. Only the value of `mix` at the frame-start falling tick is transmitted.

## Timing
- **Reset values:** `div_cnt` = 0, `i2s_bclk` = 0, `bit_cnt` = 63, `i2s_lrclk` = 1, `i2s_sdata` = 0, `sample_strobe` = 0, `frame_smp` = 0, `mix` = 0.
- **After reset deasserts (cycle 0 = first cycle with `reset` low):**
  - The first rising BCLK edge occurs after BCLK_HALF cycles.
  - The first falling BCLK edge occurs after 2·BCLK_HALF cycles. On that edge `bit_cnt` = 0, `i2s_lrclk` = 0, `sample_strobe` = 1, and `frame_smp` is latched.
- **Frame period:** 128·BCLK_HALF `clk_27m` cycles (512 at default). `sample_strobe` period is identical.
- **Input-to-pin latency:** at most 1 cycle (mix register) plus wait until the next frame start, plus 1 BCLK period until the MSB appears.
- **Reset mid-frame:** all outputs return to reset values on the next clock edge. The partial frame is abandoned; no glitch pulse on `sample_strobe`.
- **Simultaneous events:** a `mute` or `atten` change in the same cycle as frame latch uses the mix registered in the previous cycle (1-cycle rule).
- **Saturation:** applies only at `atten` = 0. For `atten` ≥ 1 the shifted value always fits in 16 bits.

## Test plan
- **Reset / first frame:** hold `reset` for 5 cycles, then release. All outputs must match the reset values listed above. At the default BCLK_HALF = 4, the first `i2s_bclk` rise is at cycle 4, the first fall is at cycle 8 with `sample_strobe` = 1, and `sample_strobe` repeats every 512 cycles.
- **Silence:** `psg_in` = 0x80, `aux_in` = 0, `atten` = 0. Both slots must decode to 0x0000, and `i2s_sdata` stays 0 for the whole frame.
- **Positive saturation:** `psg_in` = 0xFF, `aux_in` = 0x7FFF, `atten` = 0. Left and right must decode to 0x7FFF. With `psg_in` = 0x00 and `aux_in` = 0x8000, both must decode to 0x8000.
- **Attenuation:** `psg_in` = 0xC0 (→ 0x2000), `aux_in` = 0, `atten` = 3. Both slots must decode to 0x0400. Then set `mute` = 1; the next frame must decode to 0x0000.
- **Frame isolation:** change `aux_in` from 0x1234 to 0x4321 at slot position 8 of a left slot. The current frame must decode to 0x1234 on both channels, and the next frame to 0x4321. Also check that the MSB appears one BCLK after each LRCLK edge.
- **Reset mid-frame:** assert `reset` for 1 cycle at `bit_cnt` = 40. Outputs must take reset values on the next cycle. Timing must then resume exactly as in the first scenario, with no extra `sample_strobe` pulse.
